wifi_reset_sequencer: RTL and testbench
=======================================

# wifi_reset_sequencer

Sits directly downstream of the WiFi reset PIO and drives the WiFi module's reset pin. The PIO output (`sw_rst_n`) is a raw software level with no timing guarantees. This block turns it into a reset with a guaranteed minimum low width, then enforces the module's boot time before raising `wifi_ready`. It also exposes an Avalon-MM slave for status, a one-shot software pulse trigger, and a count of resets issued.

## Interface
- `ASSERT_CYCLES`, default 5000: minimum low width of `wifi_rst_n`, in clk cycles; must be ≥1.
- `BOOT_CYCLES`, default 25000000: wait after release before ready; must be ≥1.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `sw_rst_n` in 1: level from the reset PIO; same clk domain; 0 requests reset.
- `address` in 2: Avalon word address.
- `chipselect` in 1: Avalon select.
- `write_n` in 1: Avalon write strobe, active-low.
- `writedata` in 32: Avalon write data.
- `readdata` out 32: Avalon read data; combinational, zero wait states.
- `wifi_rst_n` out 1: registered drive to the WiFi reset pin.
- `wifi_ready` out 1: registered; 1 only in READY.

## Operation
- States: ASSERT, BOOT, READY. One counter of width `$clog2(max(ASSERT_CYCLES, BOOT_CYCLES)+1)`. Counter is cleared on every state entry.
- `trig` = `chipselect` & ~`write_n` & (`address`==0) & `writedata[0]`.
- `req` = ~`sw_rst_n` | `trig`.
- On `reset_n` low, asynchronously:
  - state = ASSERT, counter = 0
  - `wifi_rst_n` = 0, `wifi_ready` = 0
  - `rst_count` = 0
- ASSERT:
  - `wifi_rst_n` = 0.
  - If `req`, counter = 0 (this stretches the low time).
  - Else if counter == `ASSERT_CYCLES`-1, go to BOOT.
  - Else counter+1.
- BOOT:
  - `wifi_rst_n` = 1.
  - If `req`, go to ASSERT.
  - Else if counter == `BOOT_CYCLES`-1, go to READY.
  - Else counter+1.
- READY: `wifi_rst_n` = 1, `wifi_ready` = 1. If `req`, go to ASSERT.
- `rst_count` (16-bit, saturating at 0xFFFF):
  - Increments on each BOOT→ASSERT or READY→ASSERT transition.
  - Does not increment at hardware reset or on a `req` seen while already in ASSERT.
  - Simultaneous `trig` and low `sw_rst_n` count as one entry (+1).
- Registers:
  - Address 0 read: `{29'b0, state[1:0], wifi_ready}`, with ASSERT=0, BOOT=1, READY=2.
  - Address 0 write, bit0=1: trigger a pulse. Bit0=0: no effect. Other bits ignored.
  - Address 1 read: `{16'b0, rst_count}`. Writes ignored.
  - Addresses 2 and 3: read 0, writes ignored.

## Timing
- `req` sampled high at edge k → `wifi_rst_n` is 0 from edge k. Latency is one registered stage.
- Low width for a trigger pulse or a 1-cycle `sw_rst_n` pulse is exactly `ASSERT_CYCLES`+1 cycles. The request cycle counts as a cleared-counter cycle.
- Low width for `sw_rst_n` held low for L cycles is L+`ASSERT_CYCLES` cycles.
- After release, `wifi_ready` rises exactly `BOOT_CYCLES` cycles after `wifi_rst_n` rises.
- After `reset_n` deasserts, with `sw_rst_n`=1 and no trigger:
  - `wifi_rst_n` rises after `ASSERT_CYCLES` edges.
  - `wifi_ready` rises `BOOT_CYCLES` edges later.
- `req` in BOOT or READY: `wifi_ready` drops on the same edge `wifi_rst_n` falls.
- `readdata` reflects register state before the current edge.

## Structure
- Shared package `wifi_rst_pkg`:
  - State enum, with ASSERT=0, BOOT=1, READY=2.
  - Register address constants: `REG_CTRL_STATUS`=0, `REG_COUNT`=1.
  - Constant `RST_COUNT_W`=16.
- Single module, no sub-module. Counter, FSM and register mux together fit in ~150–250 lines.

## Test plan
All scenarios use `ASSERT_CYCLES`=4, `BOOT_CYCLES`=8.
- **Power-up.** Release `reset_n` with `sw_rst_n`=1.
  - `wifi_rst_n` rises at edge 4 and `wifi_ready` at edge 12.
  - Address 0 reads 0x5 (state 2, ready 1); address 1 reads 0.
- **Software trigger.** From READY, write 0x1 to address 0.
  - `wifi_rst_n` is low for exactly 5 cycles; `wifi_ready` returns 8 cycles after release.
  - Address 1 reads 1.
- **Held PIO level.** Hold `sw_rst_n` low 20 cycles in READY.
  - `wifi_rst_n` is low for 24 cycles; `rst_count` = 1.
- **Re-request in BOOT.** Pulse `sw_rst_n` low at BOOT counter 5.
  - Output returns to ASSERT, counter restarts, `rst_count` = 2.
  - `wifi_ready` does not rise until a full 4+8 sequence completes.
- **Simultaneous events and saturation.**
  - Trigger and `sw_rst_n` low on the same cycle in READY → `rst_count` +1 only.
  - Preload `rst_count` to 0xFFFF via force, then trigger → stays 0xFFFF.
- **Reset mid-operation and ignored writes.**
  - Assert `reset_n` mid-BOOT → `wifi_rst_n`=0, `wifi_ready`=0 and `rst_count`=0 immediately, without a clock edge.
  - Write 0x0 to address 0 → no effect.
  - Write to address 1 → count unchanged.

Source files
------------

// File: rtl/wifi_reset_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// wifi_rst_pkg
// Shared types and constants for the WiFi reset sequencer.
//   state_e          : sequencer state encoding, also the value read back in
//                      the status register (ASSERT=0, BOOT=1, READY=2)
//   REG_CTRL_STATUS  : word address of the control/status register
//   REG_COUNT        : word address of the reset counter register
//   RST_COUNT_W      : width of the saturating reset counter
//   max_int()        : elaboration-time helper for sizing the shared timer
// ---------------------------------------------------------------------------
package wifi_rst_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_BOOT   = 2'd1,
        ST_READY  = 2'd2
    } state_e;

    localparam logic [1:0] REG_CTRL_STATUS = 2'd0;
    localparam logic [1:0] REG_COUNT       = 2'd1;

    localparam int RST_COUNT_W = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/wifi_reset_sequencer_if.sv
// ---------------------------------------------------------------------------
// wifi_reset_sequencer_if
// Avalon-MM slave port of the WiFi reset sequencer (2-bit word address,
// 32-bit data, zero wait states, combinational readdata).
//   address     : word address
//   chipselect  : slave select
//   write_n     : write strobe, active-low
//   writedata   : write data
//   readdata    : read data, driven by the slave
// Modports: master (bus side), slave (sequencer side).
// ---------------------------------------------------------------------------
interface wifi_reset_sequencer_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/wifi_reset_sequencer.sv
// ---------------------------------------------------------------------------
// wifi_reset_sequencer
// Turns the raw software reset level from the WiFi reset PIO into a reset
// with a guaranteed minimum low width, then holds off wifi_ready for the
// module's boot time. Status, a one-shot reset trigger and a saturating
// count of issued resets are available over Avalon-MM.
//
// Ports
//   clk         : system clock
//   reset_n     : asynchronous active-low reset
//   sw_rst_n    : PIO reset level (0 requests reset), clk domain
//   avs         : Avalon-MM slave (wifi_reset_sequencer_if.slave)
//   wifi_rst_n  : registered drive to the WiFi reset pin
//   wifi_ready  : registered, high only in READY
//
// Register map (word addresses)
//   0 : read  {29'b0, state[1:0], wifi_ready}; write bit0=1 fires a reset
//   1 : read  {16'b0, rst_count}; writes ignored
//   2,3 : read 0; writes ignored
//
// State      | meaning
// -----------+----------------------------------------------------------
// ST_ASSERT  | wifi_rst_n low; timing minimum low width, restarted by req
// ST_BOOT    | wifi_rst_n high; timing module boot, req aborts to ASSERT
// ST_READY   | wifi_rst_n high, wifi_ready high; req aborts to ASSERT
// ---------------------------------------------------------------------------
module wifi_reset_sequencer
    import wifi_rst_pkg::*;
#(
    parameter int ASSERT_CYCLES = 5000,
    parameter int BOOT_CYCLES   = 25000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sw_rst_n,
    wifi_reset_sequencer_if.slave  avs,
    output logic                   wifi_rst_n,
    output logic                   wifi_ready
);

    localparam int CNT_W = $clog2(max_int(ASSERT_CYCLES, BOOT_CYCLES) + 1);

    localparam logic [CNT_W-1:0] ASSERT_TC = CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOOT_TC   = CNT_W'(BOOT_CYCLES - 1);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   req_q;
    logic                   wifi_rst_n_q;
    logic                   wifi_ready_q;
    logic [RST_COUNT_W-1:0] rst_count_q;
    logic [RST_COUNT_W-1:0] rst_count_d;

    logic                   trig;
    logic                   req;
    logic [31:0]            rdata;
    logic                   unused_wdata;

    assign trig = avs.chipselect & ~avs.write_n
                & (avs.address == REG_CTRL_STATUS) & avs.writedata[0];
    assign req  = ~sw_rst_n | trig;

    assign rst_count_d = (rst_count_q == '1) ? rst_count_q
                                             : rst_count_q + RST_COUNT_W'(1);

    // req_q keeps the counter cleared for one extra cycle after the last
    // request, so the cycle in which req was presented is itself counted as
    // a cleared-counter cycle: a one-cycle request yields ASSERT_CYCLES+1
    // low cycles and a request held L cycles yields L+ASSERT_CYCLES.
    // Coming out of hardware reset there is no such cycle, so the pin
    // releases after exactly ASSERT_CYCLES edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_ASSERT;
            cnt_q        <= '0;
            req_q        <= 1'b0;
            wifi_rst_n_q <= 1'b0;
            wifi_ready_q <= 1'b0;
            rst_count_q  <= '0;
        end else begin
            req_q <= req;
            unique case (state_q)
                ST_ASSERT: begin
                    if (req || req_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == ASSERT_TC) begin
                        state_q      <= ST_BOOT;
                        cnt_q        <= '0;
                        wifi_rst_n_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_BOOT: begin
                    if (req) begin
                        state_q      <= ST_ASSERT;
                        cnt_q        <= '0;
                        wifi_rst_n_q <= 1'b0;
                        wifi_ready_q <= 1'b0;
                        rst_count_q  <= rst_count_d;
                    end else if (cnt_q == BOOT_TC) begin
                        state_q      <= ST_READY;
                        cnt_q        <= '0;
                        wifi_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (req) begin
                        state_q      <= ST_ASSERT;
                        cnt_q        <= '0;
                        wifi_rst_n_q <= 1'b0;
                        wifi_ready_q <= 1'b0;
                        rst_count_q  <= rst_count_d;
                    end
                end
                default: begin
                    state_q      <= ST_ASSERT;
                    cnt_q        <= '0;
                    wifi_rst_n_q <= 1'b0;
                    wifi_ready_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (avs.address)
            REG_CTRL_STATUS: rdata = {29'b0, state_q, wifi_ready_q};
            REG_COUNT:       rdata = {{(32-RST_COUNT_W){1'b0}}, rst_count_q};
            default:         rdata = '0;
        endcase
    end

    // Only bit0 of writedata has a meaning.
    assign unused_wdata = ^avs.writedata[31:1];

    assign avs.readdata = rdata;
    assign wifi_rst_n   = wifi_rst_n_q;
    assign wifi_ready   = wifi_ready_q;

endmodule

// File: tb/tb_wifi_reset_sequencer.sv
module tb_wifi_reset_sequencer;
    import wifi_rst_pkg::*;

    localparam int A = 4;
    localparam int B = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic sw_rst_n;
    logic wifi_rst_n;
    logic wifi_ready;

    wifi_reset_sequencer_if bus ();

    wifi_reset_sequencer #(
        .ASSERT_CYCLES (A),
        .BOOT_CYCLES   (B)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_rst_n   (sw_rst_n),
        .avs        (bus.slave),
        .wifi_rst_n (wifi_rst_n),
        .wifi_ready (wifi_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic rst_n;
        logic ready;
        int   cyc;
    } ev_t;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
    } rd_t;

    ev_t ev_q[$];
    rd_t rd_q[$];

    int checks   = 0;
    int failures = 0;
    logic [1:0] prev = 2'b00;

    // Monitor: any change of {wifi_rst_n, wifi_ready} must match the next
    // expected event (value and cycle); every read cycle pops a read entry.
    always @(negedge clk) begin
        ev_t e;
        rd_t r;
        if ({wifi_rst_n, wifi_ready} !== prev) begin
            checks++;
            if (ev_q.size() == 0) begin
                failures++;
                $display("FAIL out_event: got rst_n=%0b ready=%0b at cycle %0d, required no change",
                         wifi_rst_n, wifi_ready, cyc);
            end else begin
                e = ev_q.pop_front();
                if (wifi_rst_n !== e.rst_n || wifi_ready !== e.ready || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL out_event: got rst_n=%0b ready=%0b at cycle %0d, required rst_n=%0b ready=%0b at cycle %0d",
                             wifi_rst_n, wifi_ready, cyc, e.rst_n, e.ready, e.cyc);
                end
            end
            prev = {wifi_rst_n, wifi_ready};
        end
        if (bus.chipselect === 1'b1 && bus.write_n === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL read: unexpected read of addr %0d got 0x%08h at cycle %0d",
                         bus.address, bus.readdata, cyc);
            end else begin
                r = rd_q.pop_front();
                if (bus.readdata !== r.data) begin
                    failures++;
                    $display("FAIL read_addr%0d: got 0x%08h, required 0x%08h at cycle %0d",
                             r.addr, bus.readdata, r.data, cyc);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input logic r, input logic y, input int c);
        ev_q.push_back('{rst_n: r, ready: y, cyc: c});
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] d);
        rd_q.push_back('{addr: a, data: d});
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        step();
        bus.chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Trigger from READY: low 5 cycles (A+1), ready B cycles after release.
    task automatic sw_trigger();
        int m;
        m = cyc;
        expect_ev(1'b0, 1'b0, m + 1);
        expect_ev(1'b1, 1'b0, m + 1 + A + 1);
        expect_ev(1'b1, 1'b1, m + 1 + A + 1 + B);
        wr(REG_CTRL_STATUS, 32'h1);
    endtask

    initial begin
        int m;
        reset_n        = 1'b0;
        sw_rst_n       = 1'b1;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;
        step(3);

        // Reset state
        rd(REG_CTRL_STATUS, 32'h0);
        rd(REG_COUNT, 32'h0);

        // Power-up: rst_n rises at edge 4, ready at edge 12
        m = cyc;
        expect_ev(1'b1, 1'b0, m + 4);
        expect_ev(1'b1, 1'b1, m + 12);
        reset_n = 1'b1;
        step(14);
        rd(REG_CTRL_STATUS, 32'h5);
        rd(REG_COUNT, 32'h0);

        // Software trigger
        sw_trigger();
        step(15);
        rd(REG_COUNT, 32'h1);

        // PIO held low 20 cycles: low width 24
        m = cyc;
        expect_ev(1'b0, 1'b0, m + 1);
        expect_ev(1'b1, 1'b0, m + 25);
        expect_ev(1'b1, 1'b1, m + 33);
        sw_rst_n = 1'b0;
        step(20);
        sw_rst_n = 1'b1;
        step(14);
        rd(REG_COUNT, 32'h2);

        // Re-request in BOOT at counter 5
        m = cyc;
        expect_ev(1'b0, 1'b0, m + 1);
        expect_ev(1'b1, 1'b0, m + 6);
        expect_ev(1'b0, 1'b0, m + 12);
        expect_ev(1'b1, 1'b0, m + 17);
        expect_ev(1'b1, 1'b1, m + 25);
        wr(REG_CTRL_STATUS, 32'h1);
        step(7);
        rd(REG_CTRL_STATUS, 32'h2);
        step(2);
        sw_rst_n = 1'b0;
        step();
        sw_rst_n = 1'b1;
        step(14);
        rd(REG_COUNT, 32'h4);

        // Trigger and PIO low together: one entry
        m = cyc;
        expect_ev(1'b0, 1'b0, m + 1);
        expect_ev(1'b1, 1'b0, m + 6);
        expect_ev(1'b1, 1'b1, m + 14);
        sw_rst_n = 1'b0;
        wr(REG_CTRL_STATUS, 32'h1);
        sw_rst_n = 1'b1;
        step(15);
        rd(REG_COUNT, 32'h5);

        // Saturation
        force dut.rst_count_q = 16'hFFFF;
        #1;
        release dut.rst_count_q;
        rd(REG_COUNT, 32'hFFFF);
        sw_trigger();
        step(15);
        rd(REG_COUNT, 32'hFFFF);

        // Ignored writes
        wr(REG_CTRL_STATUS, 32'h0);
        wr(REG_CTRL_STATUS, 32'hFFFF_FFFE);
        wr(2'd2, 32'h1);
        wr(2'd3, 32'h1);
        wr(REG_COUNT, 32'h1234);
        step(3);
        rd(REG_CTRL_STATUS, 32'h5);
        rd(REG_COUNT, 32'hFFFF);
        rd(2'd2, 32'h0);
        rd(2'd3, 32'h0);

        // Reset mid-BOOT, asynchronous
        m = cyc;
        expect_ev(1'b0, 1'b0, m + 1);
        expect_ev(1'b1, 1'b0, m + 6);
        wr(REG_CTRL_STATUS, 32'h1);
        step(7);
        bus.address = REG_COUNT;
        expect_ev(1'b0, 1'b0, m + 8);
        reset_n = 1'b0;
        #1;
        chk("async_wifi_rst_n", {31'b0, wifi_rst_n}, 32'h0);
        chk("async_wifi_ready", {31'b0, wifi_ready}, 32'h0);
        chk("async_rst_count", bus.readdata, 32'h0);
        step(2);

        // Power-up again after mid-operation reset
        m = cyc;
        expect_ev(1'b1, 1'b0, m + 4);
        expect_ev(1'b1, 1'b1, m + 12);
        reset_n = 1'b1;
        step(14);
        rd(REG_CTRL_STATUS, 32'h5);
        rd(REG_COUNT, 32'h0);
        step(2);

        checks++;
        if (ev_q.size() != 0) begin
            failures++;
            $display("FAIL event_drain: %0d output events never seen, required 0", ev_q.size());
        end
        checks++;
        if (rd_q.size() != 0) begin
            failures++;
            $display("FAIL read_drain: %0d reads never seen, required 0", rd_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
